// File: rtl/time_display_pkg.sv
// Shared types and constants for the time display: page encoding, scan
// states, segment glyphs and the pin polarity of the LED digits.
package time_display_pkg;

  typedef enum logic [1:0] {
    PAGE_HH = 2'd0,
    PAGE_MM = 2'd1,
    PAGE_SS = 2'd2
  } page_e;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // Snapshot of the time inputs, held for one whole three-digit frame.
  typedef struct packed {
    logic       pm;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
  } frame_t;

  // Segment and anode pins are both driven low to light.
  localparam logic ACTIVE_LOW = 1'b1;

  // Logical (1 = lit) glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG7_BLANK = 7'h00;
  localparam logic [6:0] SEG7_DASH  = 7'h40;
  localparam logic [6:0] SEG7_UNDER = 7'h08;
  localparam logic [6:0] SEG7_A     = 7'h77;
  localparam logic [6:0] SEG7_P     = 7'h73;

  // Entry n holds the glyph for decimal digit n.
  localparam logic [9:0][6:0] SEG7_DIGITS = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Pin value for a dark digit.
  localparam logic [7:0] SEG_PINS_OFF = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0] AN_PINS_OFF  = ACTIVE_LOW ? 3'b111 : 3'b000;

  // Convert a logical glyph plus decimal point into {dp,g,f,e,d,c,b,a} pins.
  function automatic logic [7:0] seg_pins(input logic dp, input logic [6:0] segs);
    return ACTIVE_LOW ? ~{dp, segs} : {dp, segs};
  endfunction

  // Anode pins enabling exactly one digit; bit 2 is the leftmost digit.
  function automatic logic [2:0] an_pins(input logic [1:0] idx);
    logic [2:0] onehot;
    onehot = 3'b001 << idx;
    return ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  // Page shown while a field is being edited.
  function automatic page_e page_for_sel(input logic [1:0] sel);
    case (sel)
      2'd0:    return PAGE_SS;
      2'd1:    return PAGE_MM;
      default: return PAGE_HH;
    endcase
  endfunction

endpackage

// File: rtl/time_display_seg7_decode.sv
// BCD nibble to logical 7-segment glyph; nibbles above 9 render as a dash.
module seg7_decode
  import time_display_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  // Pure lookup; invalid codes are shown, not corrected.
  always_comb begin
    o_segs = SEG7_DASH;
    if (i_nibble <= 4'd9) o_segs = SEG7_DIGITS[i_nibble];
  end

endmodule

// File: rtl/time_display.sv
// Three-digit multiplexed time display with rotating HH/MM/SS pages,
// a per-frame input snapshot and blink feedback while editing.
module time_display
  import time_display_pkg::*;
#(
  parameter int P_PAGE_SECS = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick_scan,
  input  logic       i_pulse_n,
  input  logic       i_wr,
  input  logic [1:0] i_sel,
  input  logic       i_pm,
  input  logic [7:0] i_hh,
  input  logic [7:0] i_mm,
  input  logic [7:0] i_ss,
  output logic [7:0] o_seg,
  output logic [2:0] o_an
);

  localparam logic [3:0] LAST_CNT = 4'(P_PAGE_SECS - 1);

  scan_state_e state_q, state_d;
  logic        adv_q, adv_d;
  logic [1:0]  idx_q, idx_d;
  frame_t      frame_q, frame_d;
  logic [7:0]  seg_q, seg_d;
  logic [2:0]  an_q, an_d;
  page_e       page_q, page_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        hidden_q, hidden_d;
  logic [1:0]  sel_q, sel_d;

  logic [1:0]  idx_nxt;
  logic        enter_drive;
  frame_t      live, cur;
  logic [7:0]  field;
  logic [3:0]  nibble;
  logic [6:0]  nib_segs;
  logic [6:0]  glyph;
  logic        hide_lo, hide_hi;
  logic [7:0]  digit_pins;

  assign live = '{pm: i_pm, hh: i_hh, mm: i_mm, ss: i_ss};

  seg7_decode u_seg7_decode (
    .i_nibble (nibble),
    .o_segs   (nib_segs)
  );

  // Render the glyph for the digit about to be driven.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    idx_nxt = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    // Digit 0 opens a frame and is rendered from the values being captured.
    cur     = (idx_nxt == 2'd0) ? live : frame_q;
    field   = cur.ss;
    glyph   = SEG7_UNDER;
    case (page_q)
      PAGE_HH: begin
        field = cur.hh;
        glyph = cur.pm ? SEG7_P : SEG7_A;
      end
      PAGE_MM: begin
        field = cur.mm;
        glyph = SEG7_DASH;
      end
      default: begin
        field = cur.ss;
        glyph = SEG7_UNDER;
      end
    endcase
    nibble  = (idx_nxt == 2'd0) ? field[3:0] : field[7:4];
    hide_lo = hidden_q && i_wr && (i_sel != 2'd3);
    hide_hi = hidden_q && i_wr && (i_sel == 2'd3);
    if (idx_nxt == 2'd2) begin
      digit_pins = hide_hi ? SEG_PINS_OFF : seg_pins(1'b0, glyph);
    end else begin
      digit_pins = hide_lo ? SEG_PINS_OFF
                 : seg_pins((idx_nxt == 2'd1) && (page_q == PAGE_HH), nib_segs);
    end
  end

  // Scan FSM: a tick blanks for one cycle, then the next digit is driven.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    seg_d       = seg_q;
    an_d        = an_q;
    adv_d       = i_tick_scan;
    enter_drive = (state_q == ST_BLANK) && adv_q && !i_tick_scan;
    if (i_tick_scan) begin
      state_d = ST_BLANK;
      seg_d   = SEG_PINS_OFF;
      an_d    = AN_PINS_OFF;
    end else if (enter_drive) begin
      state_d = ST_DRIVE;
      idx_d   = idx_nxt;
      seg_d   = digit_pins;
      an_d    = an_pins(idx_nxt);
      if (idx_nxt == 2'd0) frame_d = live;
    end
  end

  // Page rotation in run mode; page follows the edited field in edit mode.
  always_comb begin
    page_d = page_q;
    cnt_d  = cnt_q;
    if (i_wr) begin
      page_d = page_for_sel(i_sel);
      cnt_d  = 4'd0;
    end else if (i_pulse_n) begin
      if (cnt_q >= LAST_CNT) begin
        cnt_d = 4'd0;
        case (page_q)
          PAGE_HH: page_d = PAGE_MM;
          PAGE_MM: page_d = PAGE_SS;
          default: page_d = PAGE_HH;
        endcase
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Blink phase: toggles per second while editing, visible otherwise.
  always_comb begin
    sel_d    = i_sel;
    hidden_d = hidden_q;
    if (!i_wr || (i_sel != sel_q)) hidden_d = 1'b0;
    else if (i_pulse_n)            hidden_d = ~hidden_q;
  end

  // State registers with synchronous reset taking priority over all strobes.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_BLANK;
      adv_q    <= 1'b0;
      idx_q    <= 2'd2;
      frame_q  <= '0;
      seg_q    <= SEG_PINS_OFF;
      an_q     <= AN_PINS_OFF;
      page_q   <= PAGE_HH;
      cnt_q    <= 4'd0;
      hidden_q <= 1'b0;
      sel_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      adv_q    <= adv_d;
      idx_q    <= idx_d;
      frame_q  <= frame_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      page_q   <= page_d;
      cnt_q    <= cnt_d;
      hidden_q <= hidden_d;
      sel_q    <= sel_d;
    end
  end

  assign o_seg = seg_q;
  assign o_an  = an_q;

endmodule

// File: tb/tb_time_display.sv
// Directed bench for time_display; glyph pins are active-low {dp,g..a}.
module tb_time_display;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_tick_scan = 1'b0;
  logic       i_pulse_n = 1'b0;
  logic       i_wr = 1'b0;
  logic [1:0] i_sel = 2'd0;
  logic       i_pm = 1'b0;
  logic [7:0] i_hh = 8'h00;
  logic [7:0] i_mm = 8'h00;
  logic [7:0] i_ss = 8'h00;
  logic [7:0] o_seg;
  logic [2:0] o_an;

  int vectors = 0;
  int miscompares = 0;

  // Hand-derived pin patterns.
  localparam logic [7:0] G0 = 8'hC0, G1 = 8'hF9, G2 = 8'hA4, G3 = 8'hB0, G4 = 8'h99;
  localparam logic [7:0] G5 = 8'h92, G6 = 8'h82, G9 = 8'h90;
  localparam logic [7:0] G1DP = 8'h79, GDASH = 8'hBF, GUND = 8'hF7;
  localparam logic [7:0] GA = 8'h88, GP = 8'h8C, GOFF = 8'hFF;
  // {blank,drive} anode pairs for digits 2,1,0.
  localparam logic [17:0] AN_FRAME = 18'b111_011_111_101_111_110;

  time_display #(.P_PAGE_SECS(2)) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_tick_scan (i_tick_scan),
    .i_pulse_n   (i_pulse_n),
    .i_wr        (i_wr),
    .i_sel       (i_sel),
    .i_pm        (i_pm),
    .i_hh        (i_hh),
    .i_mm        (i_mm),
    .i_ss        (i_ss),
    .o_seg       (o_seg),
    .o_an        (o_an)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One tick: returns {blank-cycle an, drive-cycle an} and the driven segments.
  task automatic scan_digit(input bit with_pulse, output logic [7:0] seg, output logic [5:0] an);
    i_tick_scan = 1'b1;
    i_pulse_n   = with_pulse;
    step();
    i_tick_scan = 1'b0;
    i_pulse_n   = 1'b0;
    an[5:3] = o_an;
    step();
    an[2:0] = o_an;
    seg     = o_seg;
  endtask

  // Three ticks; segs = {d2,d1,d0}, ans = {d2 pair, d1 pair, d0 pair}.
  task automatic scan_frame(output logic [23:0] segs, output logic [17:0] ans);
    logic [7:0] s;
    logic [5:0] a;
    for (int d = 0; d < 3; d++) begin
      scan_digit(1'b0, s, a);
      segs[d*8 +: 8] = s;
      ans[d*6 +: 6]  = a;
    end
  endtask

  task automatic pulse();
    i_pulse_n = 1'b1;
    step();
    i_pulse_n = 1'b0;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_tick_scan = 1'b1;
    i_pulse_n = 1'b1;
    step();
    i_reset = 1'b0;
    i_tick_scan = 1'b0;
    i_pulse_n = 1'b0;
    vectors++;
    if (o_an !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_an got=%b exp=111", o_an);
    end
    vectors++;
    if (o_seg !== GOFF) begin
      miscompares++;
      $display("FAIL reset_seg got=%h exp=ff", o_seg);
    end
    repeat (3) step();
    vectors++;
    if (o_an !== 3'b111) begin
      miscompares++;
      $display("FAIL reset_idle_an got=%b exp=111", o_an);
    end
  endtask

  task automatic test_first_frame();
    logic [23:0] segs;
    logic [17:0] ans;
    i_hh = 8'h12; i_pm = 1'b1; i_mm = 8'h34; i_ss = 8'h56;
    scan_frame(segs, ans);
    vectors++;
    if (ans !== AN_FRAME) begin
      miscompares++;
      $display("FAIL first_frame_an got=%b exp=%b", ans, AN_FRAME);
    end
    vectors++;
    if (segs !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL first_frame_seg got=%h exp=%h", segs, {GP, G1DP, G2});
    end
  endtask

  task automatic test_rotation();
    logic [23:0] segs;
    logic [17:0] ans;
    logic [23:0] exp [6];
    exp[0] = {GP, G1DP, G2};
    exp[1] = {GDASH, G3, G4};
    exp[2] = {GDASH, G3, G4};
    exp[3] = {GUND, G5, G6};
    exp[4] = {GUND, G5, G6};
    exp[5] = {GP, G1DP, G2};
    for (int k = 0; k < 6; k++) begin
      pulse();
      scan_frame(segs, ans);
      vectors++;
      if (segs !== exp[k]) begin
        miscompares++;
        $display("FAIL rotation_pulse%0d got=%h exp=%h", k + 1, segs, exp[k]);
      end
    end
  endtask

  task automatic test_edit_blink();
    logic [23:0] segs;
    logic [17:0] ans;
    logic [23:0] vis, hid;
    i_mm = 8'h59;
    i_wr = 1'b1;
    i_sel = 2'd1;
    step();
    vis = {GDASH, G5, G9};
    hid = {GDASH, GOFF, GOFF};
    scan_frame(segs, ans);
    vectors++;
    if (segs !== vis) begin
      miscompares++;
      $display("FAIL blink_start got=%h exp=%h", segs, vis);
    end
    for (int k = 1; k <= 4; k++) begin
      pulse();
      scan_frame(segs, ans);
      vectors++;
      if (segs !== ((k % 2 == 1) ? hid : vis)) begin
        miscompares++;
        $display("FAIL blink_pulse%0d got=%h exp=%h", k, segs, (k % 2 == 1) ? hid : vis);
      end
    end
    pulse();  // hidden again before switching field
    i_sel = 2'd3;
    step();
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL sel_change_visible got=%h exp=%h", segs, {GP, G1DP, G2});
    end
    pulse();
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GOFF, G1DP, G2}) begin
      miscompares++;
      $display("FAIL pm_field_hidden got=%h exp=%h", segs, {GOFF, G1DP, G2});
    end
    i_wr = 1'b0;
    step();
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL wr_fall_page got=%h exp=%h", segs, {GP, G1DP, G2});
    end
    pulse();
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL wr_fall_count1 got=%h exp=%h", segs, {GP, G1DP, G2});
    end
    pulse();
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GDASH, G5, G9}) begin
      miscompares++;
      $display("FAIL wr_fall_count2 got=%h exp=%h", segs, {GDASH, G5, G9});
    end
  endtask

  task automatic test_frame_snapshot();
    logic [7:0] s0, s1, s2;
    logic [5:0] a;
    pulse();
    pulse();  // MM -> SS
    i_ss = 8'h09;
    scan_digit(1'b0, s0, a);
    i_ss = 8'h10;
    scan_digit(1'b0, s1, a);
    scan_digit(1'b0, s2, a);
    vectors++;
    if ({s2, s1, s0} !== {GUND, G0, G9}) begin
      miscompares++;
      $display("FAIL snapshot_frame got=%h exp=%h", {s2, s1, s0}, {GUND, G0, G9});
    end
    scan_digit(1'b0, s0, a);
    scan_digit(1'b0, s1, a);
    scan_digit(1'b0, s2, a);
    vectors++;
    if ({s2, s1, s0} !== {GUND, G1, G0}) begin
      miscompares++;
      $display("FAIL snapshot_next got=%h exp=%h", {s2, s1, s0}, {GUND, G1, G0});
    end
  endtask

  task automatic test_invalid_bcd();
    logic [23:0] segs;
    logic [17:0] ans;
    i_ss = 8'h3C;
    scan_frame(segs, ans);
    vectors++;
    if (segs !== {GUND, G3, GDASH}) begin
      miscompares++;
      $display("FAIL invalid_bcd got=%h exp=%h", segs, {GUND, G3, GDASH});
    end
  endtask

  task automatic test_tick_with_pulse();
    logic [7:0] s0, s1, s2;
    logic [5:0] a;
    pulse();                   // count 1 on SS page
    scan_digit(1'b1, s0, a);   // second pulse lands with the tick
    scan_digit(1'b0, s1, a);
    scan_digit(1'b0, s2, a);
    vectors++;
    if ({s2, s1, s0} !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL tick_with_pulse got=%h exp=%h", {s2, s1, s0}, {GP, G1DP, G2});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] s0;
    logic [5:0] a;
    logic [23:0] segs;
    logic [17:0] ans;
    pulse();
    pulse();  // HH -> MM
    scan_digit(1'b0, s0, a);
    vectors++;
    if (s0 !== G9) begin
      miscompares++;
      $display("FAIL mid_frame_digit0 got=%h exp=%h", s0, G9);
    end
    i_reset = 1'b1;
    i_tick_scan = 1'b1;
    step();
    i_reset = 1'b0;
    i_tick_scan = 1'b0;
    vectors++;
    if ({o_an, o_seg} !== {3'b111, GOFF}) begin
      miscompares++;
      $display("FAIL mid_reset_out got=%b/%h exp=111/ff", o_an, o_seg);
    end
    step();
    vectors++;
    if (o_an !== 3'b111) begin
      miscompares++;
      $display("FAIL mid_reset_idle got=%b exp=111", o_an);
    end
    scan_frame(segs, ans);
    vectors++;
    if (ans !== AN_FRAME) begin
      miscompares++;
      $display("FAIL post_reset_an got=%b exp=%b", ans, AN_FRAME);
    end
    vectors++;
    if (segs !== {GP, G1DP, G2}) begin
      miscompares++;
      $display("FAIL post_reset_page got=%h exp=%h", segs, {GP, G1DP, G2});
    end
  endtask

  initial begin
    step();
    test_reset();
    test_first_frame();
    test_rotation();
    test_edit_blink();
    test_frame_snapshot();
    test_invalid_bcd();
    test_tick_with_pulse();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/time_display.md
TIME_DISPLAY -- requirements
Module: time_display

Interface
REQ-001 SHALL have parameter P_PAGE_SECS, default 2: number of i_pulse_n pulses each page is shown in run mode; legal range 1..15.
REQ-002 SHALL have port i_clk, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port i_tick_scan, input, 1: one-cycle digit-refresh strobe, nominally 1 kHz.
REQ-005 SHALL have port i_pulse_n, input, 1: one-cycle 1 s strobe; drives page rotation and blink.
REQ-006 SHALL have port i_wr, input, 1: edit mode when high.
REQ-007 SHALL have port i_sel, input, 2: edited field; 0 = ss, 1 = mm, 2 = hh, 3 = pm.
REQ-008 SHALL have port i_pm, input, 1: PM flag from the time counters.
REQ-009 SHALL have ports i_hh, i_mm, i_ss, input, 8 each: BCD time; [7:4] = tens, [3:0] = units.
REQ-010 SHALL have port o_seg, output, 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-011 SHALL have port o_an, output, 3: active-low digit enables; bit 2 = leftmost digit.

Function
REQ-012 SHALL run a scan FSM with states BLANK and DRIVE; each i_tick_scan moves to BLANK, with o_an = 111 for exactly the next cycle.
REQ-013 SHALL advance the digit index 0->1->2->0 on the cycle after BLANK, enter DRIVE, and drive one o_an bit low together with the matching o_seg in that same registered cycle.
REQ-014 SHALL snapshot i_hh, i_mm, i_ss and i_pm into a frame register when the digit index wraps 2->0, so that all three digits of a frame show one consistent time.
REQ-015 SHALL hold a page register with values HH, MM and SS.
REQ-016 HH page SHALL show: digit2 = 'A' or 'P' from the snapshotted i_pm; digit1/digit0 = hh tens/units; dp of digit1 lit.
REQ-017 MM page SHALL show: digit2 = '-' (segment g only); digit1/digit0 = mm.
REQ-018 SS page SHALL show: digit2 = '_' (segment d only); digit1/digit0 = ss.
REQ-019 SHALL render any BCD nibble >9 as '-'; the input value is not corrected.
REQ-020 Run mode (i_wr = 0): SHALL count i_pulse_n and, on reaching P_PAGE_SECS, rotate the page HH->MM->SS->HH and clear the count.
REQ-021 Edit mode (i_wr = 1): page SHALL be SS for sel 0, MM for sel 1, and HH for sel 2 or 3, taking effect the cycle after i_sel or i_wr changes; the rotation count is held at 0.
REQ-022 On the falling edge of i_wr, the page SHALL remain as it is and the rotation count SHALL restart from 0.
REQ-023 Blink: SHALL toggle the blink phase on each i_pulse_n while i_wr = 1; the phase SHALL be forced to visible when i_wr = 0 and on any i_sel change.
REQ-024 When the blink phase is hidden: digit1/digit0 SHALL be blank (FF) for sel 0..2; digit2 SHALL be blank for sel 3.
REQ-025 When i_tick_scan and i_pulse_n arrive in the same cycle, both SHALL take effect in that cycle; a page change becomes visible from the next DRIVE.

Reset
REQ-026 On i_reset: o_an = 111, o_seg = FF, FSM = BLANK, digit index = 2 (first DRIVE after the next tick is digit 0), page = HH, rotation count = 0, blink = visible, frame register = 0.
REQ-027 Reset SHALL take priority over every strobe in the same cycle; a reset during DRIVE SHALL blank the outputs on the next edge.

Structure
REQ-028 Shared package SHALL hold the page encoding, segment constants (blank, '-', '_', 'A', 'P', digits 0-9) and the active-low polarity.
REQ-029 SHALL instantiate one combinational sub-module, seg7_decode (nibble -> 7 segments, invalid -> '-').

Verification
REQ-030 Reset, then 3 ticks with hh = 12, pm = 1 -> digits 0/1/2 show '2' / '1'+dp / 'P'; o_an sequence 110, 101, 011, each preceded by one 111 cycle.
REQ-031 Run mode, P_PAGE_SECS = 2, 6 i_pulse_n -> page HH->MM->SS->HH, changing on pulses 2, 4 and 6.
REQ-032 i_wr = 1, sel = 1, mm = 59, 4 i_pulse_n -> digit1/digit0 alternate blank / '5','9'; digit2 stays '-'.
REQ-033 ss changes 09->10 between digit0 and digit1 of a frame -> the frame shows 09; the next frame shows 10.
REQ-034 i_ss = 8'h3C -> digit0 shows '-' (o_seg = BF), digit1 shows '3'.
REQ-035 i_reset asserted mid-frame together with i_tick_scan -> next cycle o_an = 111, o_seg = FF, page = HH.
